// File: rtl/page_rank.sv
// Prefix-sum engine: streams N_BEATS 512-bit beats through running 32-bit-lane inclusive
// prefix sums. Results are written to a host-chosen base, and the 64-bit grand total is exposed via softreg.
module page_rank #(
    parameter int unsigned N_BEATS     = 4,
    parameter logic [63:0] READ_BASE   = 64'h0,
    parameter logic [63:0] WRITE_ADDR0 = 64'h0,
    parameter logic [63:0] DONE_ALL    = 64'h8
) (
    input  logic         clk,
    input  logic         rst,
    output logic [15:0]  arid_m,
    output logic [63:0]  araddr_m,
    output logic [7:0]   arlen_m,
    output logic [2:0]   arsize_m,
    output logic         arvalid_m,
    input  logic         arready_m,
    input  logic [15:0]  rid_m,
    input  logic [511:0] rdata_m,
    input  logic [1:0]   rresp_m,
    input  logic         rlast_m,
    input  logic         rvalid_m,
    output logic         rready_m,
    output logic [15:0]  awid_m,
    output logic [63:0]  awaddr_m,
    output logic [7:0]   awlen_m,
    output logic [2:0]   awsize_m,
    output logic         awvalid_m,
    input  logic         awready_m,
    output logic [15:0]  wid_m,
    output logic [511:0] wdata_m,
    output logic [63:0]  wstrb_m,
    output logic         wlast_m,
    output logic         wvalid_m,
    input  logic         wready_m,
    input  logic [15:0]  bid_m,
    input  logic [1:0]   bresp_m,
    input  logic         bvalid_m,
    output logic         bready_m,
    input  logic         softreg_req_valid,
    input  logic         softreg_req_isWrite,
    input  logic [31:0]  softreg_req_addr,
    input  logic [63:0]  softreg_req_data,
    output logic         softreg_resp_valid,
    output logic [63:0]  softreg_resp_data
);
    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned BEAT_W = LANES * LANE_W;
    localparam int unsigned IDX_W  = $clog2(N_BEATS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RA   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WA   = 3'd3;
    localparam logic [2:0] S_WD   = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]        state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [63:0]       total, total_nxt;
    logic [63:0]       base, base_nxt;
    logic              done, done_nxt;
    logic              pend, pend_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [BEAT_W-1:0] sum_beat;
    logic [63:0]       acc;
    logic              resp_v_nxt;
    logic [63:0]       resp_d_nxt;
    logic              wr_start, rd_req;

    assign arid_m   = '0;
    assign arlen_m  = '0;
    assign arsize_m = 3'd6;
    assign awid_m   = '0;
    assign awlen_m  = '0;
    assign awsize_m = 3'd6;
    assign wid_m    = '0;
    assign wstrb_m  = '1;
    assign wlast_m  = wvalid_m;

    logic unused_inputs;
    assign unused_inputs = ^{rid_m, rresp_m, rlast_m, bid_m, bresp_m};

    // Next-state, datapath and softreg response decode
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        total_nxt  = total;
        base_nxt   = base;
        done_nxt   = done;
        pend_nxt   = pend;
        beat_nxt   = beat;
        resp_v_nxt = 1'b0;
        resp_d_nxt = '0;
        sum_beat   = '0;
        acc        = total;

        for (int j = 0; j < LANES; j++) begin
            acc = acc + 64'(rdata_m[j*LANE_W +: LANE_W]);
            sum_beat[j*LANE_W +: LANE_W] = acc[LANE_W-1:0];
        end

        wr_start = softreg_req_valid && softreg_req_isWrite && (softreg_req_addr == 32'(WRITE_ADDR0));
        rd_req   = softreg_req_valid && !softreg_req_isWrite;

        case (state)
            S_IDLE, S_DONE: begin
                if (wr_start) begin
                    base_nxt  = softreg_req_data;
                    total_nxt = '0;
                    idx_nxt   = '0;
                    done_nxt  = 1'b0;
                    state_nxt = S_RA;
                end
            end
            S_RA: if (arready_m) state_nxt = S_RD;
            S_RD: begin
                if (rvalid_m) begin
                    beat_nxt  = sum_beat;
                    total_nxt = acc;
                    state_nxt = S_WA;
                end
            end
            S_WA: if (awready_m) state_nxt = S_WD;
            S_WD: if (wready_m) state_nxt = S_WB;
            S_WB: begin
                if (bvalid_m) begin
                    idx_nxt = idx + IDX_W'(1);
                    if (idx_nxt == IDX_W'(N_BEATS)) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RA;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (rd_req) begin
            if (softreg_req_addr == 32'(WRITE_ADDR0)) begin
                resp_v_nxt = 1'b1;
                resp_d_nxt = base;
            end else if (softreg_req_addr == 32'(DONE_ALL)) begin
                if (done) begin
                    resp_v_nxt = 1'b1;
                    resp_d_nxt = total;
                end else begin
                    pend_nxt = 1'b1;
                end
            end else begin
                resp_v_nxt = 1'b1;
                resp_d_nxt = '0;
            end
        end

        // A parked DONE_ALL read (including one arriving right now) is answered on DONE entry
        if (pend_nxt && (state != S_DONE) && (state_nxt == S_DONE)) begin
            resp_v_nxt = 1'b1;
            resp_d_nxt = total_nxt;
            pend_nxt   = 1'b0;
        end
    end

    // State and registered outputs; valids track the next state so they are high exactly in their state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= S_IDLE;
            idx                <= '0;
            total              <= '0;
            base               <= '0;
            done               <= 1'b0;
            pend               <= 1'b0;
            beat               <= '0;
            arvalid_m          <= 1'b0;
            araddr_m           <= '0;
            rready_m           <= 1'b0;
            awvalid_m          <= 1'b0;
            awaddr_m           <= '0;
            wvalid_m           <= 1'b0;
            wdata_m            <= '0;
            bready_m           <= 1'b0;
            softreg_resp_valid <= 1'b0;
            softreg_resp_data  <= '0;
        end else begin
            state              <= state_nxt;
            idx                <= idx_nxt;
            total              <= total_nxt;
            base               <= base_nxt;
            done               <= done_nxt;
            pend               <= pend_nxt;
            beat               <= beat_nxt;
            arvalid_m          <= (state_nxt == S_RA);
            araddr_m           <= READ_BASE + 64'({idx_nxt, 6'b0});
            rready_m           <= (state_nxt == S_RD);
            awvalid_m          <= (state_nxt == S_WA);
            awaddr_m           <= base_nxt + 64'({idx_nxt, 6'b0});
            wvalid_m           <= (state_nxt == S_WD);
            wdata_m            <= beat_nxt;
            bready_m           <= (state_nxt == S_WB);
            softreg_resp_valid <= resp_v_nxt;
            softreg_resp_data  <= resp_d_nxt;
        end
    end
endmodule

// File: tb/tb_page_rank.sv
// Self-checking bench for page_rank: AXI slave memory model with random stalls
// and a flat-list prefix-sum reference model.
module tb_page_rank;
    logic         clk;
    logic         rst;
    logic [15:0]  arid_m, awid_m, wid_m;
    logic [63:0]  araddr_m, awaddr_m;
    logic [7:0]   arlen_m, awlen_m;
    logic [2:0]   arsize_m, awsize_m;
    logic         arvalid_m, arready_m;
    logic [15:0]  rid_m, bid_m;
    logic [511:0] rdata_m, wdata_m;
    logic [1:0]   rresp_m, bresp_m;
    logic         rlast_m, rvalid_m, rready_m;
    logic         awvalid_m, awready_m;
    logic [63:0]  wstrb_m;
    logic         wlast_m, wvalid_m, wready_m;
    logic         bvalid_m, bready_m;
    logic         softreg_req_valid, softreg_req_isWrite;
    logic [31:0]  softreg_req_addr;
    logic [63:0]  softreg_req_data;
    logic         softreg_resp_valid;
    logic [63:0]  softreg_resp_data;

    page_rank dut (
        .clk(clk), .rst(rst),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
        .awvalid_m(awvalid_m), .awready_m(awready_m),
        .wid_m(wid_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m),
        .wvalid_m(wvalid_m), .wready_m(wready_m),
        .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
        .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
        .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
        .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [511:0] src_mem [0:15];
    logic [511:0] dst_mem [0:15];
    logic [511:0] exp_beat [0:3];
    logic [63:0]  exp_total;
    bit           stall_en = 1'b0;

    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int resp_cnt = 0, resp_b_at = 0, stable_err = 0;
    logic [63:0] resp_last = '0;

    // AXI slave + softreg response monitor, all on the falling edge
    initial begin
        logic [63:0]  rq[$], awq[$];
        logic [511:0] wq[$];
        int           bpend;
        logic         p_arv, p_rr, p_awv, p_wv, p_br;
        logic [63:0]  p_araddr, p_awaddr;
        logic [511:0] p_wdata;
        arready_m = 0; awready_m = 0; wready_m = 0; rvalid_m = 0; bvalid_m = 0;
        rdata_m = '0; rid_m = '0; rresp_m = '0; rlast_m = 0; bid_m = '0; bresp_m = '0;
        for (int i = 0; i < 16; i++) dst_mem[i] = '0;
        bpend = 0; p_arv = 0; p_rr = 0; p_awv = 0; p_wv = 0; p_br = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rq.delete(); awq.delete(); wq.delete(); bpend = 0;
                p_arv = 0; p_rr = 0; p_awv = 0; p_wv = 0; p_br = 0;
                arready_m = 0; awready_m = 0; wready_m = 0; rvalid_m = 0; bvalid_m = 0; rlast_m = 0;
                continue;
            end
            if (p_arv && arready_m) begin ar_cnt++; rq.push_back(p_araddr); end
            if (rvalid_m && p_rr) begin r_cnt++; rvalid_m = 0; rlast_m = 0; end
            if (p_awv && awready_m) begin aw_cnt++; awq.push_back(p_awaddr); end
            if (p_wv && wready_m) begin w_cnt++; wq.push_back(p_wdata); end
            while (awq.size() > 0 && wq.size() > 0) begin
                dst_mem[int'(awq.pop_front() >> 6) & 15] = wq.pop_front();
                bpend++;
            end
            if (bvalid_m && p_br) begin b_cnt++; bvalid_m = 0; end
            if (p_arv && !arready_m && !(arvalid_m && araddr_m == p_araddr)) stable_err++;
            if (p_awv && !awready_m && !(awvalid_m && awaddr_m == p_awaddr)) stable_err++;
            if (p_wv && !wready_m && !(wvalid_m && wlast_m && wdata_m == p_wdata)) stable_err++;
            if (softreg_resp_valid) begin
                resp_cnt++; resp_last = softreg_resp_data; resp_b_at = b_cnt;
            end
            p_arv = arvalid_m; p_araddr = araddr_m; p_rr = rready_m;
            p_awv = awvalid_m; p_awaddr = awaddr_m; p_wv = wvalid_m; p_wdata = wdata_m;
            p_br = bready_m;
            arready_m = stall_en ? ($urandom_range(0, 3) == 0) : 1'b1;
            awready_m = stall_en ? ($urandom_range(0, 3) == 0) : 1'b1;
            wready_m  = stall_en ? ($urandom_range(0, 3) == 0) : 1'b1;
            if (!rvalid_m && rq.size() > 0 && (!stall_en || $urandom_range(0, 2) == 0)) begin
                rvalid_m = 1; rlast_m = 1;
                rdata_m = src_mem[int'(rq.pop_front() >> 6) & 15];
            end
            if (!bvalid_m && bpend > 0 && (!stall_en || $urandom_range(0, 3) == 0)) begin
                bvalid_m = 1; bpend--;
            end
        end
    end

    // Reference: concatenate all source lanes into one list and take its running 64-bit sum
    task automatic run_model();
        logic [31:0] lanes[$];
        logic [63:0] run;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 16; j++) lanes.push_back(src_mem[k][j*32 +: 32]);
        run = '0;
        foreach (lanes[i]) begin
            run = run + {32'h0, lanes[i]};
            exp_beat[i / 16][(i % 16)*32 +: 32] = run[31:0];
        end
        exp_total = run;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j++) src_mem[k][j*32 +: 32] = $urandom();
    endtask

    task automatic sr_req(input bit wr, input logic [31:0] a, input logic [63:0] d);
        @(negedge clk);
        softreg_req_valid = 1; softreg_req_isWrite = wr; softreg_req_addr = a; softreg_req_data = d;
        @(negedge clk);
        softreg_req_valid = 0; softreg_req_isWrite = 0; softreg_req_addr = '0; softreg_req_data = '0;
    endtask

    task automatic read_reg(input logic [31:0] a, output int cnt, output logic [63:0] d);
        int c0;
        c0 = resp_cnt;
        sr_req(1'b0, a, 64'h0);
        repeat (3) @(negedge clk);
        cnt = resp_cnt - c0;
        d = resp_last;
    endtask

    task automatic wait_b(input int target, input string nm);
        bit ok;
        ok = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (b_cnt >= target) begin ok = 1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: b handshakes %0d, required %0d", nm, b_cnt, target);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_dst(input int beat0, input string nm);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (dst_mem[beat0 + k] !== exp_beat[k]) begin
                n_fail++;
                $display("FAIL %s beat %0d: got %h required %h", nm, k, dst_mem[beat0 + k], exp_beat[k]);
            end
        end
    endtask

    task automatic check_val(input string nm, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 0;
        softreg_req_valid = 0; softreg_req_isWrite = 0; softreg_req_addr = '0; softreg_req_data = '0;
        repeat (3) @(negedge clk);
        check_val("reset valids", 64'({arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m, softreg_resp_valid}), 64'h0);
        check_val("reset araddr/awaddr", araddr_m | awaddr_m, 64'h0);
        n_tests++;
        if (wdata_m !== '0) begin n_fail++; $display("FAIL reset wdata: got %h required 0", wdata_m); end
        rst = 1;
        repeat (3) @(negedge clk);
        check_val("idle arvalid", 64'(arvalid_m), 64'h0);
    endtask

    task automatic test_ones();
        int cnt; logic [63:0] d; int b0; bit bad;
        for (int k = 0; k < 16; k++) src_mem[k] = {16{32'h1}};
        b0 = b_cnt;
        sr_req(1'b1, 32'h0, 64'd256);
        wait_b(b0 + 4, "ones");
        while ($time < 10000) @(negedge clk);
        read_reg(32'h8, cnt, d);
        check_val("ones resp count", 64'(cnt), 64'd1);
        check_val("ones total", d, 64'd64);
        bad = 0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 16; j++)
                if (dst_mem[4 + k][j*32 +: 32] !== 32'(16*k + j + 1)) bad = 1;
        check_val("ones dest lanes", 64'(bad), 64'h0);
    endtask

    task automatic test_pending();
        int c0, b0;
        fill_random(); run_model();
        b0 = b_cnt; c0 = resp_cnt;
        sr_req(1'b1, 32'h0, 64'd256);
        sr_req(1'b0, 32'h8, 64'h0);
        repeat (3) @(negedge clk);
        check_val("pending early resp", 64'(resp_cnt - c0), 64'h0);
        wait_b(b0 + 4, "pending");
        check_val("pending resp count", 64'(resp_cnt - c0), 64'd1);
        check_val("pending resp timing", 64'(resp_b_at), 64'(b0 + 4));
        check_val("pending total", resp_last, exp_total);
        check_dst(4, "pending dest");
    endtask

    task automatic test_overflow();
        int cnt, b0; logic [63:0] d; logic [511:0] all_f;
        for (int k = 0; k < 16; k++) src_mem[k] = '0;
        src_mem[0][31:0] = 32'hFFFF_FFFF;
        all_f = {16{32'hFFFF_FFFF}};
        b0 = b_cnt;
        sr_req(1'b1, 32'h0, 64'd512);
        wait_b(b0 + 4, "overflow");
        read_reg(32'h8, cnt, d);
        check_val("overflow total", d, 64'hFFFF_FFFF);
        n_tests++;
        if (dst_mem[8] !== all_f || dst_mem[11] !== all_f) begin
            n_fail++;
            $display("FAIL overflow lanes: got %h / %h required all ones", dst_mem[8], dst_mem[11]);
        end
    endtask

    task automatic test_stall();
        int a0, aw0, w0, b0, cnt; logic [63:0] d;
        fill_random(); run_model();
        a0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        stall_en = 1;
        sr_req(1'b1, 32'h0, 64'd256);
        wait_b(b0 + 4, "stall");
        repeat (30) @(negedge clk);
        stall_en = 0;
        check_val("stall AR count", 64'(ar_cnt - a0), 64'd4);
        check_val("stall AW count", 64'(aw_cnt - aw0), 64'd4);
        check_val("stall W count", 64'(w_cnt - w0), 64'd4);
        check_val("stall B count", 64'(b_cnt - b0), 64'd4);
        check_val("stall held stable", 64'(stable_err), 64'h0);
        check_dst(4, "stall dest");
        read_reg(32'h8, cnt, d);
        check_val("stall total", d, exp_total);
    endtask

    task automatic test_restart();
        int cnt, b0, a0; logic [63:0] d;
        fill_random(); run_model();
        b0 = b_cnt; a0 = ar_cnt;
        sr_req(1'b1, 32'h0, 64'd256);
        for (int c = 0; c < 100 && ar_cnt == a0; c++) @(negedge clk);
        sr_req(1'b1, 32'h0, 64'd512);
        sr_req(1'b1, 32'h10, 64'd768);
        wait_b(b0 + 4, "restart first");
        repeat (40) @(negedge clk);
        check_val("busy write ignored (B count)", 64'(b_cnt - b0), 64'd4);
        read_reg(32'h0, cnt, d);
        check_val("base readback", d, 64'd256);
        read_reg(32'h20, cnt, d);
        check_val("other addr resp count", 64'(cnt), 64'd1);
        check_val("other addr data", d, 64'h0);
        check_dst(4, "restart dest 256");
        sr_req(1'b1, 32'h0, 64'd512);
        wait_b(b0 + 8, "restart second");
        read_reg(32'h8, cnt, d);
        check_val("restart total from zero", d, exp_total);
        check_dst(8, "restart dest 512");
    endtask

    task automatic test_rst_mid();
        int a0, c0, b0, cnt; logic [63:0] d;
        a0 = ar_cnt;
        sr_req(1'b1, 32'h0, 64'd256);
        for (int c = 0; c < 200 && ar_cnt < a0 + 2; c++) @(negedge clk);
        #2 rst = 0;
        #1;
        check_val("mid rst valids", 64'({arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m, softreg_resp_valid}), 64'h0);
        check_val("mid rst addr", araddr_m | awaddr_m, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1;
        fill_random(); run_model();
        c0 = resp_cnt;
        sr_req(1'b0, 32'h8, 64'h0);
        repeat (30) @(negedge clk);
        check_val("post rst read pending", 64'(resp_cnt - c0), 64'h0);
        b0 = b_cnt;
        sr_req(1'b1, 32'h0, 64'd256);
        wait_b(b0 + 4, "post rst job");
        check_val("post rst resp count", 64'(resp_cnt - c0), 64'd1);
        check_val("post rst total", resp_last, exp_total);
        read_reg(32'h8, cnt, d);
        check_val("post rst done read", d, exp_total);
    endtask

    initial begin
        rst = 0;
        test_reset();
        test_ones();
        test_pending();
        test_overflow();
        test_stall();
        test_restart();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
